// File: rtl/sobel_pkg.sv
// Shared types, window index map and helper functions for the Sobel gradient pipe.
// Contents:
//   pixel_t / window_t      8-bit pixel and packed 3x3 window (index = 3*col + row)
//   IDX_*                   window positions by column (L/M/R) and row (T/M/B)
//   MAX_GRAD, SAT_LIMIT     largest |gradient| and the 8-bit output ceiling
//   weighted_sum()          1-2-1 weighted sum of three pixels (10-bit result)
//   saturate()              clamp an 11-bit magnitude into one pixel
package sobel_pkg;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [0:8] window_t;

  localparam int IDX_LT = 0;
  localparam int IDX_LM = 1;
  localparam int IDX_LB = 2;
  localparam int IDX_MT = 3;
  localparam int IDX_MM = 4;
  localparam int IDX_MB = 5;
  localparam int IDX_RT = 6;
  localparam int IDX_RM = 7;
  localparam int IDX_RB = 8;

  localparam int MAX_GRAD  = 1020;
  localparam int SAT_LIMIT = 255;

  // Largest result is 4*255 = 1020, which fits in 10 bits.
  function automatic logic [9:0] weighted_sum(input pixel_t a, input pixel_t mid, input pixel_t c);
    return {2'b00, a} + {1'b0, mid, 1'b0} + {2'b00, c};
  endfunction

  function automatic pixel_t saturate(input logic [10:0] m);
    return (m > 11'(SAT_LIMIT)) ? 8'(SAT_LIMIT) : m[7:0];
  endfunction

endpackage

// File: rtl/sobel_gradient_pipe_abs_diff.sv
// Signed difference and absolute difference of two 10-bit unsigned operands.
// Ports:
//   a, b   in   10-bit unsigned operands
//   diff   out  a - b, signed 11 bit
//   mag    out  |a - b|, 10 bit (operands never exceed 1020, so it cannot overflow)
module sobel_abs_diff (
  input  logic        [9:0]  a,
  input  logic        [9:0]  b,
  output logic signed [10:0] diff,
  output logic        [9:0]  mag
);

  logic signed [10:0] neg_diff;

  assign diff     = $signed({1'b0, a}) - $signed({1'b0, b});
  assign neg_diff = -diff;
  assign mag      = diff[10] ? neg_diff[9:0] : diff[9:0];

endmodule

// File: rtl/sobel_gradient_pipe.sv
// Sobel gradient pipeline: accepts one 3x3 window per handshake and emits the
// saturated magnitude |Gx|+|Gy| plus an edge flag, with a per-frame pixel counter.
// Ports:
//   clk, n_rst             clock, synchronous active-low reset
//   win_valid/win_ready    input window handshake (win_ready is the global advance)
//   window_in, threshold   3x3 window and edge threshold, captured together
//   pix_valid/pix_ready    output pixel handshake
//   pix_out, edge_out      saturated magnitude and (pix_out >= threshold)
//   frame_done             one-cycle pulse after the handshake of the last pixel of a frame
//   pix_count              index of the next output pixel within the frame
module sobel_gradient_pipe
  import sobel_pkg::*;
#(
  parameter  int IMG_W   = 256,
  parameter  int IMG_H   = 256,
  localparam int NUM_OUT = (IMG_W - 2) * (IMG_H - 2),
  localparam int CNT_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             win_valid,
  output logic             win_ready,
  input  window_t          window_in,
  input  pixel_t           threshold,
  output logic             pix_valid,
  input  logic             pix_ready,
  output pixel_t           pix_out,
  output logic             edge_out,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_OUT - 1);
  localparam logic signed [10:0] GRAD_HI  = 11'(MAX_GRAD);
  localparam logic signed [10:0] GRAD_LO  = -11'(MAX_GRAD);

  logic adv;

  // Capture stage: the raw window lands here on acceptance, so S1..S3 follow
  // on the next three edges and the result appears three edges after accept.
  logic    s0_valid;
  window_t s0_win;
  pixel_t  s0_thr;

  logic       s1_valid;
  logic [9:0] s1_l, s1_r, s1_t, s1_b;
  pixel_t     s1_thr;

  logic       s2_valid;
  logic [9:0] s2_gx_abs, s2_gy_abs;
  pixel_t     s2_thr;

  logic s3_valid;

  logic signed [10:0] gx, gy;
  logic        [9:0]  gx_abs, gy_abs;
  logic        [10:0] mag;
  pixel_t             mag_sat;

  // One advance signal moves every stage at once; a stalled output freezes all.
  assign adv       = !s3_valid || pix_ready;
  assign win_ready = adv;
  assign pix_valid = s3_valid;

  sobel_abs_diff u_gx (
    .a    (s1_r),
    .b    (s1_l),
    .diff (gx),
    .mag  (gx_abs)
  );

  sobel_abs_diff u_gy (
    .a    (s1_b),
    .b    (s1_t),
    .diff (gy),
    .mag  (gy_abs)
  );

  assign mag     = {1'b0, s2_gx_abs} + {1'b0, s2_gy_abs};
  assign mag_sat = saturate(mag);

  always_comb begin
    if (s1_valid) begin
      assert (gx <= GRAD_HI && gx >= GRAD_LO && gy <= GRAD_HI && gy >= GRAD_LO);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      pix_out  <= '0;
      edge_out <= 1'b0;
    end else if (adv) begin
      s0_valid <= win_valid;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      pix_out  <= mag_sat;
      edge_out <= (mag_sat >= s2_thr);
    end
  end

  // Datapath registers carry no reset; their contents are qualified by the valids.
  always_ff @(posedge clk) begin
    if (adv) begin
      s0_win    <= window_in;
      s0_thr    <= threshold;
      s1_l      <= weighted_sum(s0_win[IDX_LT], s0_win[IDX_LM], s0_win[IDX_LB]);
      s1_r      <= weighted_sum(s0_win[IDX_RT], s0_win[IDX_RM], s0_win[IDX_RB]);
      s1_t      <= weighted_sum(s0_win[IDX_LT], s0_win[IDX_MT], s0_win[IDX_RT]);
      s1_b      <= weighted_sum(s0_win[IDX_LB], s0_win[IDX_MB], s0_win[IDX_RB]);
      s1_thr    <= s0_thr;
      s2_gx_abs <= gx_abs;
      s2_gy_abs <= gy_abs;
      s2_thr    <= s1_thr;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (s3_valid && pix_ready) begin
        if (pix_count == LAST_IDX) begin
          pix_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_count <= pix_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Scoreboard bench for sobel_gradient_pipe built with a 4x4 image (4 output pixels per frame).
module tb_sobel_gradient_pipe;
  import sobel_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       win_valid;
  logic       win_ready;
  window_t    window_in;
  pixel_t     threshold;
  logic       pix_valid;
  logic       pix_ready;
  pixel_t     pix_out;
  logic       edge_out;
  logic       frame_done;
  logic [1:0] pix_count;

  typedef struct packed {
    pixel_t pix;
    logic   edge_bit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sobel_gradient_pipe #(.IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .window_in  (window_in),
    .threshold  (threshold),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_out    (pix_out),
    .edge_out   (edge_out),
    .frame_done (frame_done),
    .pix_count  (pix_count)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present a window and hold it until accepted; the expected result is queued at acceptance.
  task automatic applyStimulus(input window_t w, input pixel_t thr, input int ep, input bit ee);
    bit acc = 1'b0;
    int guard = 0;
    window_in = w;
    threshold = thr;
    win_valid = 1'b1;
    while (!acc && guard < 50) begin
      @(negedge clk);
      if (win_ready) begin
        acc = 1'b1;
        exp_q.push_back(exp_t'{pix: 8'(ep), edge_bit: ee});
      end
      @(posedge clk);
      guard++;
    end
    #1;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no win_ready, expected acceptance within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    win_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    n_rst     = 1'b0;
    win_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Monitor: pops on every output handshake, tracks the frame counter, checks stall stability.
  initial begin
    exp_t   e;
    int     cnt = 0;
    bit     fd_pend = 1'b0;
    bit     hold = 1'b0;
    pixel_t hp = '0;
    logic   he = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        cnt     = 0;
        fd_pend = 1'b0;
        hold    = 1'b0;
      end else begin
        checkOutput("frame_done", frame_done, fd_pend);
        checkOutput("pix_count", pix_count, cnt);
        if (hold) begin
          checkOutput("stall_valid", pix_valid, 1);
          checkOutput("stall_pix", pix_out, hp);
          checkOutput("stall_edge", edge_out, he);
        end
        fd_pend = 1'b0;
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_output: got pix_out %0d, expected no output", pix_out);
          end else begin
            e = exp_q.pop_front();
            checkOutput("pix_out", pix_out, e.pix);
            checkOutput("edge_out", edge_out, e.edge_bit);
          end
          fd_pend = (cnt == 3);
          cnt     = (cnt == 3) ? 0 : cnt + 1;
        end
        hold = pix_valid && !pix_ready;
        hp   = pix_out;
        he   = edge_out;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected end before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    window_t w;
    n_rst     = 1'b0;
    win_valid = 1'b0;
    pix_ready = 1'b1;
    window_in = '0;
    threshold = '0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    @(negedge clk);
    checkOutput("rst_pix_valid", pix_valid, 0);
    checkOutput("rst_win_ready", win_ready, 1);
    checkOutput("rst_pix_out", pix_out, 0);
    checkOutput("rst_edge_out", edge_out, 0);
    @(posedge clk);
    #1;

    // All-zero window; result must appear exactly three edges after acceptance.
    applyStimulus('0, 8'd1, 0, 1'b0);
    win_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("latency", pix_valid, (k == 4) ? 1 : 0);
    end
    @(posedge clk);
    #1;

    // Directed vectors, streamed back to back.
    applyStimulus('0, 8'd0, 0, 1'b1);
    applyStimulus({8'd10, 8'd10, 8'd10, 8'd15, 8'd15, 8'd15, 8'd20, 8'd20, 8'd20}, 8'd50, 40, 1'b0);
    applyStimulus({8'd0, 8'd0, 8'd0, 8'd128, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255}, 8'd200, 255, 1'b1);
    applyStimulus({8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0}, 8'd255, 255, 1'b1);
    applyStimulus({8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd60, 60, 1'b1);
    applyStimulus({8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd255, 254, 1'b0);
    applyStimulus({8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd255, 255, 1'b1);
    idle(8);

    // Ten windows with w5 = w7 = k: gx = gy = 2k, so pix_out = 4k; stall mid-stream.
    for (int k = 1; k <= 10; k++) begin
      if (k == 7) begin
        win_valid = 1'b0;
        pix_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          checkOutput("win_ready_full", win_ready, 0);
        end
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
      end
      w    = '0;
      w[5] = 8'(k);
      w[7] = 8'(k);
      applyStimulus(w, 8'd20, 4 * k, (4 * k >= 20));
    end
    idle(8);

    // Fresh frame: nine windows with w6 = 3k, so gx = 3k, gy = -3k, pix_out = 6k.
    pulseReset();
    for (int k = 1; k <= 9; k++) begin
      w    = '0;
      w[6] = 8'(3 * k);
      applyStimulus(w, 8'd30, 6 * k, (6 * k >= 30));
    end
    idle(8);
    @(negedge clk);
    checkOutput("count_after_9", pix_count, 1);
    @(posedge clk);
    #1;

    // Bring the count to the last index, then reset with two windows in flight.
    applyStimulus({8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd10, 20, 1'b1);
    applyStimulus({8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd50, 40, 1'b0);
    idle(8);
    @(negedge clk);
    checkOutput("count_before_abort", pix_count, 3);
    @(posedge clk);
    #1;
    applyStimulus({8'd40, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd1, 80, 1'b1);
    applyStimulus({8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd1, 100, 1'b1);
    pulseReset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("abort_pix_valid", pix_valid, 0);
      checkOutput("abort_frame_done", frame_done, 0);
      checkOutput("abort_pix_count", pix_count, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus({8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 8'd10, 10, 1'b1);
    idle(8);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
